// File: rtl/alert_diff_decode.sv
// Differential alert pair decoder: recovers a logic level from a p/n wire pair,
// flags edges as single-cycle pulses and reports signal-integrity loss.
module alert_diff_decode #(
   parameter bit AsyncOn = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic diff_pi,
   input  logic diff_ni,
   output logic level_o,
   output logic rise_o,
   output logic fall_o,
   output logic event_o,
   output logic sigint_o
);

   logic level_d;
   logic level_q;
   logic sigint_s;

   if (AsyncOn) begin : gen_async
      typedef enum logic [1:0] {
         IsStd     = 2'b00,
         IsSkewing = 2'b01,
         SigInt    = 2'b10
      } state_e;

      state_e state_d, state_q;
      logic   p_meta_q, n_meta_q;
      logic   pd_q, nd_q;
      logic   equal_s;

      assign equal_s = (pd_q == nd_q);

      // Two-flop synchronizers, reset to the idle pair (p=0, n=1)
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            p_meta_q <= 1'b0;
            n_meta_q <= 1'b1;
            pd_q     <= 1'b0;
            nd_q     <= 1'b1;
         end else begin
            p_meta_q <= diff_pi;
            n_meta_q <= diff_ni;
            pd_q     <= p_meta_q;
            nd_q     <= n_meta_q;
         end
      end

      // Skew-tolerance state register
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            state_q <= IsStd;
         end else begin
            state_q <= state_d;
         end
      end

      // Next state: one equal cycle is skew, a second one is an integrity fault
      always_comb begin
         state_d = state_q;
         case (state_q)
            IsStd:     if (equal_s) state_d = IsSkewing; else state_d = IsStd;
            IsSkewing: if (equal_s) state_d = SigInt;    else state_d = IsStd;
            SigInt:    if (equal_s) state_d = SigInt;    else state_d = IsStd;
            default:   state_d = IsStd;
         endcase
      end

      // Outputs: the level only follows pd while the pair is valid
      always_comb begin
         level_d  = level_q;
         sigint_s = 1'b0;
         case (state_q)
            IsStd: begin
               if (equal_s) level_d = level_q; else level_d = pd_q;
            end
            IsSkewing, SigInt: begin
               if (equal_s) begin
                  level_d  = level_q;
                  sigint_s = 1'b1;
               end else begin
                  level_d  = pd_q;
               end
            end
            default: begin
               level_d  = level_q;
               sigint_s = 1'b0;
            end
         endcase
      end
   end else begin : gen_sync
      logic equal_s;

      assign equal_s  = (diff_pi == diff_ni);
      // Reset gating keeps the raw-input flag quiet while the block is held
      assign sigint_s = rst_ni & equal_s;

      // Level follows p while valid, holds otherwise
      always_comb begin
         if (equal_s) begin
            level_d = level_q;
         end else begin
            level_d = diff_pi;
         end
      end
   end

   // Decoded level register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         level_q <= 1'b0;
      end else begin
         level_q <= level_d;
      end
   end

   assign level_o  = level_q;
   assign rise_o   = rst_ni & level_d & ~level_q;
   assign fall_o   = rst_ni & ~level_d & level_q;
   assign event_o  = rise_o | fall_o;
   assign sigint_o = sigint_s;

endmodule

// File: tb/tb_alert_diff_decode.sv
// Bench for alert_diff_decode: drives an async-path and a sync-path instance
// side by side and compares both against a run-length reference model.
module tb_alert_diff_decode;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic pa = 1'b0, na = 1'b1;
   logic ps = 1'b1, ns = 1'b1;
   logic lvl_a, rise_a, fall_a, ev_a, sig_a;
   logic lvl_s, rise_s, fall_s, ev_s, sig_s;

   int n_checks = 0;
   int n_err = 0;
   int cnt_rise_a = 0, cnt_fall_a = 0, cnt_sig_a = 0;

   // reference model state
   logic m_s1p, m_s1n, m_pd, m_nd, m_lvl_a, m_lvl_s;
   int   m_run;

   always #5 clk = ~clk;

   alert_diff_decode #(.AsyncOn(1'b1)) u_dut_a (
      .clk_i(clk), .rst_ni(rst_n), .diff_pi(pa), .diff_ni(na),
      .level_o(lvl_a), .rise_o(rise_a), .fall_o(fall_a), .event_o(ev_a), .sigint_o(sig_a));

   alert_diff_decode #(.AsyncOn(1'b0)) u_dut_s (
      .clk_i(clk), .rst_ni(rst_n), .diff_pi(ps), .diff_ni(ns),
      .level_o(lvl_s), .rise_o(rise_s), .fall_o(fall_s), .event_o(ev_s), .sigint_o(sig_s));

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic reset_model();
      m_s1p = 1'b0; m_s1n = 1'b1; m_pd = 1'b0; m_nd = 1'b1;
      m_run = 0; m_lvl_a = 1'b0; m_lvl_s = 1'b0;
   endtask

   // Model clock edge: m_run counts consecutive equal synchronized samples
   task automatic model_edge();
      if (!rst_n) begin
         reset_model();
      end else begin
         if (m_pd == m_nd) begin
            if (m_run < 2) m_run++;
         end else begin
            m_run   = 0;
            m_lvl_a = m_pd;
         end
         m_pd = m_s1p; m_nd = m_s1n;
         m_s1p = pa;   m_s1n = na;
         if (ps != ns) m_lvl_s = ps;
      end
   endtask

   task automatic check_outputs();
      logic eq, sig, lvd, r, f;
      eq  = (m_pd == m_nd);
      sig = eq && (m_run >= 1);
      lvd = eq ? m_lvl_a : m_pd;
      r   = rst_n & lvd & ~m_lvl_a;
      f   = rst_n & ~lvd & m_lvl_a;
      chk("a_level", lvl_a, m_lvl_a);
      chk("a_rise", rise_a, r);
      chk("a_fall", fall_a, f);
      chk("a_event", ev_a, r | f);
      chk("a_sigint", sig_a, sig);
      cnt_rise_a += int'(rise_a);
      cnt_fall_a += int'(fall_a);
      cnt_sig_a  += int'(sig_a);
      eq  = (ps == ns);
      sig = rst_n & eq;
      lvd = eq ? m_lvl_s : ps;
      r   = rst_n & lvd & ~m_lvl_s;
      f   = rst_n & ~lvd & m_lvl_s;
      chk("s_level", lvl_s, m_lvl_s);
      chk("s_rise", rise_s, r);
      chk("s_fall", fall_s, f);
      chk("s_event", ev_s, r | f);
      chk("s_sigint", sig_s, sig);
   endtask

   task automatic step(input logic ap, input logic an, input logic sp, input logic sn);
      @(posedge clk);
      model_edge();
      #1;
      pa = ap; na = an; ps = sp; ns = sn;
      @(negedge clk);
      check_outputs();
   endtask

   task automatic hold_a(input logic ap, input logic an, input int n);
      for (int i = 0; i < n; i++) step(ap, an, 1'b0, 1'b1);
   endtask

   initial begin
      int r0, f0, s0;
      logic rp, rn;
      reset_model();
      // reset with a non-idle sync pair: outputs must stay quiet
      #3;
      check_outputs();
      repeat (2) begin
         @(posedge clk);
         model_edge();
         @(negedge clk);
         check_outputs();
      end
      rst_n = 1'b1;

      // sync-path sequence (0,1)->(1,0)->(1,1)->(0,1); async held idle
      step(1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      hold_a(1'b0, 1'b1, 3);
      chk("idle_no_rise", (cnt_rise_a == 0), 1'b1);

      // clean toggle, then back to 0
      hold_a(1'b1, 1'b0, 5);
      hold_a(1'b0, 1'b1, 5);

      // one-cycle skew: one rise, no sigint
      r0 = cnt_rise_a; s0 = cnt_sig_a;
      hold_a(1'b1, 1'b1, 1);
      hold_a(1'b1, 1'b0, 5);
      chk("skew_one_rise", (cnt_rise_a - r0 == 1), 1'b1);
      chk("skew_no_sigint", (cnt_sig_a - s0 == 0), 1'b1);

      // sustained equal at level 1, then valid again at 1
      r0 = cnt_rise_a; f0 = cnt_fall_a; s0 = cnt_sig_a;
      hold_a(1'b1, 1'b1, 4);
      hold_a(1'b1, 1'b0, 5);
      chk("equal_no_events", (cnt_rise_a - r0 + cnt_fall_a - f0 == 0), 1'b1);
      chk("equal_sigint_seen", (cnt_sig_a - s0 > 0), 1'b1);

      // recovery from SigInt at level 0: no fall
      hold_a(1'b0, 1'b1, 5);
      f0 = cnt_fall_a;
      hold_a(1'b0, 1'b0, 4);
      hold_a(1'b0, 1'b1, 5);
      chk("recover_no_fall", (cnt_fall_a - f0 == 0), 1'b1);

      // double toggle straight into level 1, then reset while in SigInt
      hold_a(1'b1, 1'b0, 5);
      hold_a(1'b1, 1'b1, 4);
      chk("pre_reset_sigint", sig_a, 1'b1);
      #2;
      rst_n = 1'b0;
      pa = 1'b0; na = 1'b1;
      #1;
      reset_model();
      check_outputs();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
      rst_n = 1'b1;
      r0 = cnt_rise_a; f0 = cnt_fall_a;
      hold_a(1'b0, 1'b1, 4);
      chk("post_reset_quiet", (cnt_rise_a - r0 + cnt_fall_a - f0 == 0), 1'b1);
      // single equal cycle after reset is only skew
      s0 = cnt_sig_a;
      hold_a(1'b1, 1'b1, 1);
      hold_a(1'b0, 1'b1, 4);
      chk("post_reset_isstd", (cnt_sig_a - s0 == 0), 1'b1);

      // randomized traffic on both paths
      rp = 1'b0; rn = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 2) != 0) begin
            if ($urandom_range(0, 3) != 0) begin
               rp = 1'($urandom_range(0, 1));
               rn = ~rp;
            end else begin
               rp = 1'($urandom_range(0, 1));
               rn = rp;
            end
         end
         step(rp, rn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
